// File: rtl/ascon_mask_pkg.sv
// Shared constants and helpers for the ASCON masking front/back end:
// share-count derivations, PRNG reset seed, xorshift steps and share slicing.
package ascon_mask_pkg;

  localparam int MASK_ORDER = 2;
  localparam int LANE_W     = 64;
  localparam logic [63:0] DEFAULT_SEED = 64'h9E3779B97F4A7C15;

  function automatic int num_shares(input int d);
    return d + 1;
  endfunction

  // One 5-bit DOM S-box needs one fresh bit per share pair per S-box bit.
  function automatic int rnd_w(input int d);
    return (d + 1) * d / 2 * 5;
  endfunction

  localparam int SHARES_DEFAULT = num_shares(MASK_ORDER);

  function automatic logic [63:0] xs64_step(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  function automatic logic [31:0] xs32_step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  function automatic logic [LANE_W-1:0] get_share(
    input logic [SHARES_DEFAULT*LANE_W-1:0] vec,
    input int                               s
  );
    return vec[s*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/ascon_prng_xs.sv
// Xorshift PRNG (64- or 32-bit) with step enable, seed load and a zero-seed guard.
// Load wins over step; only the low OUT_W state bits are exported.
module ascon_prng_xs
  import ascon_mask_pkg::*;
#(
  parameter int               WIDTH = 64,
  parameter int               OUT_W = WIDTH,
  parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             step_i,
  output logic [OUT_W-1:0] state_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] next_state;

  generate
    if (WIDTH == 64) begin : g_xs64
      assign next_state = xs64_step(state_q);
    end else begin : g_xs32
      assign next_state = xs32_step(state_q);
    end
  endgenerate

  // An all-zero xorshift state is a fixed point, so a zero seed falls back to SEED.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? SEED : seed_i;
    end else if (step_i) begin
      state_d = next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/ascon_share_codec.sv
// Boolean masking codec: splits a lane into NUM_SHARES shares with PRNG64,
// recombines incoming shares, and supplies fresh S-box randomness from PRNG32.
module ascon_share_codec
  import ascon_mask_pkg::*;
#(
  parameter int          D    = MASK_ORDER,
  parameter int          W    = LANE_W,
  parameter logic [63:0] SEED = DEFAULT_SEED,
  localparam int         NUM_SHARES = num_shares(D),
  localparam int         RND_W      = rnd_w(D)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    seed_load,
  input  logic [63:0]             seed_i,
  input  logic                    enc_valid_i,
  output logic                    enc_ready_o,
  input  logic [W-1:0]            enc_data_i,
  output logic                    sh_valid_o,
  input  logic                    sh_ready_i,
  output logic [NUM_SHARES*W-1:0] sh_data_o,
  input  logic                    dec_valid_i,
  output logic                    dec_ready_o,
  input  logic [NUM_SHARES*W-1:0] dec_sh_i,
  output logic                    dec_valid_o,
  input  logic                    dec_ready_i,
  output logic [W-1:0]            dec_data_o,
  input  logic                    rnd_en_i,
  output logic [RND_W-1:0]        rnd_o
);

  localparam int KW = (D < 2) ? 1 : $clog2(D + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GEN  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [W-1:0]            acc_q, acc_d;
  logic [NUM_SHARES*W-1:0] sh_q, sh_d;
  logic                    dec_valid_q, dec_valid_d;
  logic [W-1:0]            dec_q, dec_d;

  logic                    prng64_step;
  logic [63:0]             prng64_state;
  logic [63:0]             gen_word;
  logic [W-1:0]            dec_xor;
  logic                    dec_ready;

  ascon_prng_xs #(
    .WIDTH (64),
    .OUT_W (64),
    .SEED  (SEED)
  ) u_prng64 (
    .clk     (clk),
    .rst     (rst),
    .load_i  (seed_load),
    .seed_i  (seed_i),
    .step_i  (prng64_step),
    .state_o (prng64_state)
  );

  ascon_prng_xs #(
    .WIDTH (32),
    .OUT_W (RND_W),
    .SEED  (SEED[31:0])
  ) u_prng32 (
    .clk     (clk),
    .rst     (rst),
    .load_i  (seed_load),
    .seed_i  (seed_i[31:0]),
    .step_i  (rnd_en_i),
    .state_o (rnd_o)
  );

  // The PRNG output is defined as the state after the step, i.e. the value it steps to.
  assign gen_word = xs64_step(prng64_state);

  // Encoder: share k takes the k-th fresh PRNG word, share 0 absorbs the running XOR
  // so that all shares together recombine to the accepted word.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    sh_d        = sh_q;
    prng64_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enc_valid_i) begin
          acc_d   = enc_data_i;
          k_d     = KW'(1);
          state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        prng64_step = 1'b1;
        acc_d       = acc_q ^ gen_word;
        for (int s = 1; s < NUM_SHARES; s++) begin
          if (k_q == s[KW-1:0]) begin
            sh_d[s*W +: W] = gen_word;
          end
        end
        if (k_q == D[KW-1:0]) begin
          sh_d[W-1:0] = acc_q ^ gen_word;
          state_d     = ST_OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (sh_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoder: one skid-free pipeline stage that refills in the same cycle it drains.
  always_comb begin
    dec_xor = '0;
    for (int s = 0; s < NUM_SHARES; s++) begin
      dec_xor = dec_xor ^ dec_sh_i[s*W +: W];
    end
    dec_ready   = !dec_valid_q || dec_ready_i;
    dec_valid_d = dec_valid_q;
    dec_d       = dec_q;
    if (dec_valid_i && dec_ready) begin
      dec_valid_d = 1'b1;
      dec_d       = dec_xor;
    end else if (dec_ready_i) begin
      dec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      sh_q        <= '0;
      dec_valid_q <= 1'b0;
      dec_q       <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      sh_q        <= sh_d;
      dec_valid_q <= dec_valid_d;
      dec_q       <= dec_d;
    end
  end

  assign enc_ready_o = (state_q == ST_IDLE);
  assign sh_valid_o  = (state_q == ST_OUT);
  assign sh_data_o   = sh_q;
  assign dec_ready_o = dec_ready;
  assign dec_valid_o = dec_valid_q;
  assign dec_data_o  = dec_q;

endmodule

// File: tb/tb_ascon_share_codec.sv
// Directed and randomised self-checking bench for ascon_share_codec.
module tb_ascon_share_codec;
  import ascon_mask_pkg::*;

  localparam logic [63:0] SEED_V = 64'h9E3779B97F4A7C15;
  localparam int NRAND = 2000;

  logic         clk;
  logic         rst;
  logic         seed_load;
  logic [63:0]  seed_i;
  logic         enc_valid_i;
  logic         enc_ready_o;
  logic [63:0]  enc_data_i;
  logic         sh_valid_o;
  logic         sh_ready_i;
  logic [191:0] sh_data_o;
  logic         dec_valid_i;
  logic         dec_ready_o;
  logic [191:0] dec_sh_i;
  logic         dec_valid_o;
  logic         dec_ready_i;
  logic [63:0]  dec_data_o;
  logic         rnd_en_i;
  logic [14:0]  rnd_o;

  int checks = 0;
  int errors = 0;

  ascon_share_codec dut (
    .clk         (clk),
    .rst         (rst),
    .seed_load   (seed_load),
    .seed_i      (seed_i),
    .enc_valid_i (enc_valid_i),
    .enc_ready_o (enc_ready_o),
    .enc_data_i  (enc_data_i),
    .sh_valid_o  (sh_valid_o),
    .sh_ready_i  (sh_ready_i),
    .sh_data_o   (sh_data_o),
    .dec_valid_i (dec_valid_i),
    .dec_ready_o (dec_ready_o),
    .dec_sh_i    (dec_sh_i),
    .dec_valid_o (dec_valid_o),
    .dec_ready_i (dec_ready_i),
    .dec_data_o  (dec_data_o),
    .rnd_en_i    (rnd_en_i),
    .rnd_o       (rnd_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference xorshift written with explicit concatenations.
  function automatic logic [63:0] ref_xs64(input logic [63:0] v);
    logic [63:0] t;
    t = v ^ {v[50:0], 13'b0};
    t = t ^ {7'b0, t[63:7]};
    t = t ^ {t[46:0], 17'b0};
    return t;
  endfunction

  function automatic logic [31:0] ref_xs32(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ {v[18:0], 13'b0};
    t = t ^ {17'b0, t[31:17]};
    t = t ^ {t[26:0], 5'b0};
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ev, input logic [63:0] ed, input logic sr);
    enc_valid_i = ev;
    enc_data_i  = ed;
    sh_ready_i  = sr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic encodeWord(input logic [63:0] w, input logic rdy,
                            output logic [191:0] sh, output int lat);
    applyStimulus(1'b1, w, rdy);
    tick();
    applyStimulus(1'b0, 64'd0, rdy);
    lat = 1;
    while (!sh_valid_o && lat < 10) begin
      tick();
      lat++;
    end
    sh = sh_data_o;
  endtask

  logic [191:0] sh;
  logic [63:0]  x64, m1, m2, w, exp_w, pending, seed_v;
  logic [31:0]  r32;
  int           lat;
  logic [63:0]  encq[$];
  logic [63:0]  wshq[$];
  logic [191:0] shq[$];
  logic [63:0]  decq[$];
  int           sent, got, cyc;

  initial begin
    rst = 1'b1;
    seed_load = 1'b0;
    seed_i = 64'd0;
    applyStimulus(1'b0, 64'd0, 1'b0);
    dec_valid_i = 1'b0;
    dec_sh_i = '0;
    dec_ready_i = 1'b0;
    rnd_en_i = 1'b0;
    #1;
    checkOutput("rst_enc_ready", enc_ready_o, 1);
    checkOutput("rst_sh_valid", sh_valid_o, 0);
    checkOutput("rst_sh_data", sh_data_o, 0);
    checkOutput("rst_dec_valid", dec_valid_o, 0);
    checkOutput("rst_dec_data", dec_data_o, 0);
    checkOutput("rst_rnd", rnd_o, 15'h7C15);
    tick();
    tick();
    rst = 1'b0;

    // Basic encode with the consumer always ready.
    x64 = SEED_V;
    encodeWord(64'h0123456789ABCDEF, 1'b1, sh, lat);
    checkOutput("enc_latency", lat, 3);
    m1 = ref_xs64(x64);
    m2 = ref_xs64(m1);
    x64 = m2;
    checkOutput("enc_share1", get_share(sh, 1), m1);
    checkOutput("enc_share2", get_share(sh, 2), m2);
    checkOutput("enc_recombine", get_share(sh, 0) ^ get_share(sh, 1) ^ get_share(sh, 2),
                64'h0123456789ABCDEF);
    checkOutput("enc_ready_in_out", enc_ready_o, 0);
    tick();
    checkOutput("enc_done_valid", sh_valid_o, 0);
    checkOutput("enc_done_ready", enc_ready_o, 1);

    // Backpressure on the share output.
    encodeWord(64'hFEDCBA9876543210, 1'b0, sh, lat);
    m1 = ref_xs64(x64);
    m2 = ref_xs64(m1);
    x64 = m2;
    checkOutput("bp_share1", get_share(sh, 1), m1);
    checkOutput("bp_share2", get_share(sh, 2), m2);
    checkOutput("bp_recombine", get_share(sh, 0) ^ get_share(sh, 1) ^ get_share(sh, 2),
                64'hFEDCBA9876543210);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_stable", sh_data_o, sh);
      checkOutput("bp_ready_low", enc_ready_o, 0);
      checkOutput("bp_valid_held", sh_valid_o, 1);
    end
    sh_ready_i = 1'b1;
    tick();
    checkOutput("bp_release", enc_ready_o, 1);
    sh_ready_i = 1'b0;

    // PRNG64 must not have advanced while the shares were held.
    encodeWord(64'h0, 1'b1, sh, lat);
    m1 = ref_xs64(x64);
    checkOutput("bp_no_step", get_share(sh, 1), m1);
    x64 = ref_xs64(m1);
    tick();

    // Decoder: single word, stall, then back-to-back traffic.
    dec_ready_i = 1'b1;
    dec_valid_i = 1'b1;
    dec_sh_i = {64'd4, 64'd2, 64'd1};
    tick();
    checkOutput("dec_first_valid", dec_valid_o, 1);
    checkOutput("dec_first_data", dec_data_o, 64'd7);
    dec_ready_i = 1'b0;
    dec_sh_i = {64'd32, 64'd16, 64'd8};
    #1;
    checkOutput("dec_stall_ready", dec_ready_o, 0);
    tick();
    checkOutput("dec_stall_data", dec_data_o, 64'd7);
    checkOutput("dec_stall_valid", dec_valid_o, 1);
    dec_ready_i = 1'b1;
    #1;
    checkOutput("dec_unstall_ready", dec_ready_o, 1);
    tick();
    checkOutput("dec_unstall_data", dec_data_o, 64'd56);
    for (int i = 0; i < 4; i++) begin
      m1 = 64'h1111111111111111 * (i + 1);
      m2 = 64'h0F0F0F0F0F0F0F0F << i;
      w  = 64'hA5A5A5A5A5A5A5A5 + i;
      dec_sh_i = {w, m2, m1};
      tick();
      checkOutput("dec_b2b_data", dec_data_o, m1 ^ m2 ^ w);
      checkOutput("dec_b2b_valid", dec_valid_o, 1);
    end
    dec_valid_i = 1'b0;
    tick();
    checkOutput("dec_drain_valid", dec_valid_o, 0);

    // Fresh randomness stepping and seed loading.
    r32 = 32'h7F4A7C15;
    checkOutput("rnd_idle", rnd_o, r32[14:0]);
    rnd_en_i = 1'b1;
    tick();
    r32 = ref_xs32(r32);
    checkOutput("rnd_step1", rnd_o, r32[14:0]);
    tick();
    r32 = ref_xs32(r32);
    checkOutput("rnd_step2", rnd_o, r32[14:0]);
    rnd_en_i = 1'b0;
    tick();
    checkOutput("rnd_hold", rnd_o, r32[14:0]);

    seed_load = 1'b1;
    seed_i = 64'd0;
    rnd_en_i = 1'b1;
    tick();
    seed_load = 1'b0;
    rnd_en_i = 1'b0;
    checkOutput("seed_zero_rnd", rnd_o, 15'h7C15);
    x64 = SEED_V;
    encodeWord(64'h1234, 1'b1, sh, lat);
    checkOutput("seed_zero_share1", get_share(sh, 1), ref_xs64(x64));
    tick();

    seed_v = 64'h00000001DEADBEEF;
    seed_load = 1'b1;
    seed_i = seed_v;
    rnd_en_i = 1'b1;
    tick();
    seed_load = 1'b0;
    rnd_en_i = 1'b0;
    checkOutput("seed_load_rnd", rnd_o, seed_v[14:0]);
    encodeWord(64'h5678, 1'b1, sh, lat);
    m1 = ref_xs64(seed_v);
    checkOutput("seed_load_share1", get_share(sh, 1), m1);
    checkOutput("seed_load_share2", get_share(sh, 2), ref_xs64(m1));
    tick();

    // Asynchronous reset in the middle of share generation.
    applyStimulus(1'b1, 64'hCAFEF00DCAFEF00D, 1'b1);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("rst_gen_valid", sh_valid_o, 0);
    checkOutput("rst_gen_ready", enc_ready_o, 1);
    checkOutput("rst_gen_data", sh_data_o, 0);
    checkOutput("rst_gen_rnd", rnd_o, 15'h7C15);
    rst = 1'b0;
    encodeWord(64'hCAFEF00DCAFEF00D, 1'b1, sh, lat);
    m1 = ref_xs64(SEED_V);
    checkOutput("rst_gen_share1", get_share(sh, 1), m1);
    checkOutput("rst_gen_share2", get_share(sh, 2), ref_xs64(m1));
    tick();

    // Random loopback with backpressure on both paths.
    sent = 0;
    got = 0;
    cyc = 0;
    pending = {$urandom, $urandom};
    while (got < NRAND && cyc < 40000) begin
      applyStimulus(sent < NRAND, pending, $urandom_range(0, 3) != 0);
      dec_valid_i = (shq.size() > 0) && ($urandom_range(0, 3) != 0);
      if (shq.size() > 0) dec_sh_i = shq[0];
      dec_ready_i = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (dec_valid_o && dec_ready_i) begin
        if (decq.size() == 0) begin
          checkOutput("loop_dup", 1, 0);
        end else begin
          exp_w = decq.pop_front();
          checkOutput("loop_dec", dec_data_o, exp_w);
        end
        got++;
      end
      if (dec_valid_i && dec_ready_o) begin
        decq.push_back(wshq.pop_front());
        void'(shq.pop_front());
      end
      if (sh_valid_o && sh_ready_i) begin
        w = encq.pop_front();
        checkOutput("loop_xor", get_share(sh_data_o, 0) ^ get_share(sh_data_o, 1)
                    ^ get_share(sh_data_o, 2), w);
        shq.push_back(sh_data_o);
        wshq.push_back(w);
      end
      if (enc_valid_i && enc_ready_o) begin
        encq.push_back(enc_data_i);
        sent++;
        pending = {$urandom, $urandom};
      end
      tick();
      cyc++;
    end
    applyStimulus(1'b0, 64'd0, 1'b0);
    dec_valid_i = 1'b0;
    checkOutput("loop_sent", sent, NRAND);
    checkOutput("loop_received", got, NRAND);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
